// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and width helper for the BCD conversion arbiter
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int bcd_clog2(input int value);
      int result;
      int remaining;
      result = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/double_dabble_step.sv
// rtl/double_dabble_step.sv - one combinational add-3-and-shift double-dabble iteration
module double_dabble_step #(
   parameter int INPUT_BITS    = 8,
   parameter int OUTPUT_DIGITS = 3
) (
   input  logic [OUTPUT_DIGITS*4-1:0] scratch_i,
   input  logic [INPUT_BITS-1:0]      binary_i,
   output logic [OUTPUT_DIGITS*4-1:0] scratch_o,
   output logic [INPUT_BITS-1:0]      binary_o
);

   localparam int BCD_W = OUTPUT_DIGITS * 4;

   // The top digit's MSB is shifted out, so only its low three bits are kept.
   logic [BCD_W-2:0] adjusted;
   logic [3:0]       top_digit;

   always_comb begin
      adjusted  = scratch_i[BCD_W-2:0];
      top_digit = scratch_i[BCD_W-1 -: 4];
      for (int d = 0; d < OUTPUT_DIGITS - 1; d++) begin
         if (scratch_i[d*4 +: 4] >= 4'd5) begin
            adjusted[d*4 +: 4] = scratch_i[d*4 +: 4] + 4'd3;
         end
      end
      if (top_digit >= 4'd5) begin
         adjusted[BCD_W-2 -: 3] = top_digit[2:0] + 3'd3;
      end
   end

   assign scratch_o = {adjusted, binary_i[INPUT_BITS-1]};
   assign binary_o  = {binary_i[INPUT_BITS-2:0], 1'b0};

endmodule

// File: rtl/bcd_conversion_arbiter.sv
// rtl/bcd_conversion_arbiter.sv - round-robin arbiter sharing one serial binary-to-BCD converter
module bcd_conversion_arbiter
   import bcd_pkg::*;
#(
   parameter int INPUT_BITS    = 8,
   parameter int OUTPUT_DIGITS = 3,
   parameter int REQUESTERS    = 4
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic [REQUESTERS-1:0]            Request_i,
   input  logic [REQUESTERS*INPUT_BITS-1:0] Binary_i,
   output logic [REQUESTERS-1:0]            Grant_o,
   output logic [REQUESTERS-1:0]            Done_o,
   output logic [OUTPUT_DIGITS*4-1:0]       BCD_o,
   output logic                             Busy_o
);

   localparam int BCD_W = OUTPUT_DIGITS * 4;
   localparam int CNT_W = (bcd_clog2(INPUT_BITS) < 1) ? 1 : bcd_clog2(INPUT_BITS);
   localparam int PTR_W = (bcd_clog2(REQUESTERS) < 1) ? 1 : bcd_clog2(REQUESTERS);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(INPUT_BITS - 1);
   localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(REQUESTERS - 1);

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q;
   logic [PTR_W-1:0]       winner_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [INPUT_BITS-1:0]  bin_q;
   logic [BCD_W-1:0]       scratch_q;
   logic [BCD_W-1:0]       bcd_q;
   logic                   arb_valid;
   logic [PTR_W-1:0]       arb_idx;
   logic [BCD_W-1:0]       step_scratch;
   logic [INPUT_BITS-1:0]  step_bin;

   double_dabble_step #(
      .INPUT_BITS    (INPUT_BITS),
      .OUTPUT_DIGITS (OUTPUT_DIGITS)
   ) u_step (
      .scratch_i (scratch_q),
      .binary_i  (bin_q),
      .scratch_o (step_scratch),
      .binary_o  (step_bin)
   );

   // First active request at or above the pointer, wrapping around.
   always_comb begin
      int cand;
      cand      = 0;
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= REQUESTERS) begin
            cand = cand - REQUESTERS;
         end
         if (!arb_valid && Request_i[cand]) begin
            arb_valid = 1'b1;
            arb_idx   = PTR_W'(cand);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arb_valid) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == LAST_ITER) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Grant_o = '0;
      Done_o  = '0;
      Busy_o  = (state_q != ST_IDLE);
      if (state_q == ST_SHIFT) Grant_o[winner_q] = 1'b1;
      if (state_q == ST_DONE)  Done_o[winner_q]  = 1'b1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr_q     <= '0;
         winner_q  <= '0;
         cnt_q     <= '0;
         bin_q     <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  winner_q  <= arb_idx;
                  bin_q     <= Binary_i[int'(arb_idx)*INPUT_BITS +: INPUT_BITS];
                  scratch_q <= '0;
                  cnt_q     <= '0;
               end
            end
            ST_SHIFT: begin
               scratch_q <= step_scratch;
               bin_q     <= step_bin;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) bcd_q <= step_scratch;
            end
            ST_DONE: begin
               ptr_q <= (winner_q == LAST_REQ) ? '0 : winner_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BCD_o = bcd_q;

endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// tb/tb_bcd_conversion_arbiter.sv - directed self-checking bench for bcd_conversion_arbiter
module tb_bcd_conversion_arbiter;

   logic        Clock;
   logic        Reset;
   logic [3:0]  Request_i;
   logic [31:0] Binary_i;
   logic [3:0]  Grant_o;
   logic [3:0]  Done_o;
   logic [11:0] BCD_o;
   logic        Busy_o;

   int errors = 0;
   int checks = 0;

   bcd_conversion_arbiter #(
      .INPUT_BITS    (8),
      .OUTPUT_DIGITS (3),
      .REQUESTERS    (4)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Request_i (Request_i),
      .Binary_i  (Binary_i),
      .Grant_o   (Grant_o),
      .Done_o    (Done_o),
      .BCD_o     (BCD_o),
      .Busy_o    (Busy_o)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int edges, output logic [3:0] seen);
      edges = 0;
      seen  = '0;
      while (edges < limit && seen == 4'b0) begin
         tick();
         edges++;
         seen = Done_o;
      end
   endtask

   task automatic test_reset();
      Reset     = 1'b1;
      Request_i = 4'hF;
      Binary_i  = 32'hFFFF_FFFF;
      tick();
      tick();
      checks++;
      if ({Grant_o, Done_o, BCD_o, Busy_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs got grant=%b done=%b bcd=%h busy=%b exp all zero",
                  Grant_o, Done_o, BCD_o, Busy_o);
      end
      Request_i = 4'h0;
      Reset     = 1'b0;
      tick();
   endtask

   task automatic test_single();
      Binary_i  = 32'h0000_00FF;
      Request_i = 4'b0001;
      tick();
      Request_i = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (Grant_o !== 4'b0001 || Done_o !== 4'b0000 || Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant cyc=%0d got grant=%b done=%b busy=%b exp 0001/0000/1",
                     i, Grant_o, Done_o, Busy_o);
         end
         tick();
      end
      checks++;
      if (Done_o !== 4'b0001 || Grant_o !== 4'b0000 || BCD_o !== 12'h255) begin
         errors++;
         $display("FAIL single_done got done=%b grant=%b bcd=%h exp 0001/0000/255",
                  Done_o, Grant_o, BCD_o);
      end
      tick();
      checks++;
      if (Done_o !== 4'b0000 || Busy_o !== 1'b0 || BCD_o !== 12'h255) begin
         errors++;
         $display("FAIL single_after got done=%b busy=%b bcd=%h exp 0000/0/255",
                  Done_o, Busy_o, BCD_o);
      end
   endtask

   task automatic test_all_four();
      logic [11:0] exp_bcd [4];
      logic [3:0]  seen;
      int          n;
      time         t_prev;
      exp_bcd[0] = 12'h012;
      exp_bcd[1] = 12'h034;
      exp_bcd[2] = 12'h056;
      exp_bcd[3] = 12'h078;
      t_prev = 0;
      do_reset();
      Binary_i  = {8'd78, 8'd56, 8'd34, 8'd12};
      Request_i = 4'hF;
      for (int k = 0; k < 4; k++) begin
         wait_done(40, n, seen);
         checks++;
         if (seen !== (4'b0001 << k) || BCD_o !== exp_bcd[k]) begin
            errors++;
            $display("FAIL all_four_k%0d got done=%b bcd=%h exp done=%b bcd=%h",
                     k, seen, BCD_o, 4'b0001 << k, exp_bcd[k]);
         end
         if (k == 0) begin
            checks++;
            if (n !== 9) begin
               errors++;
               $display("FAIL all_four_latency got=%0d edges exp=9", n);
            end
         end else begin
            checks++;
            if ($time - t_prev !== 100) begin
               errors++;
               $display("FAIL all_four_spacing k%0d got=%0t exp=100", k, $time - t_prev);
            end
         end
         t_prev       = $time;
         Request_i[k] = 1'b0;
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] seen;
      int         n;
      do_reset();
      Binary_i  = {8'd0, 8'd21, 8'd7, 8'd40};
      Request_i = 4'b0010;
      wait_done(40, n, seen);
      Request_i = 4'b0000;
      checks++;
      if (seen !== 4'b0010 || BCD_o !== 12'h007) begin
         errors++;
         $display("FAIL rr_first got done=%b bcd=%h exp 0010/007", seen, BCD_o);
      end
      tick();
      Request_i = 4'b0101;
      wait_done(40, n, seen);
      Request_i[2] = 1'b0;
      checks++;
      if (seen !== 4'b0100 || BCD_o !== 12'h021) begin
         errors++;
         $display("FAIL rr_second got done=%b bcd=%h exp 0100/021", seen, BCD_o);
      end
      wait_done(40, n, seen);
      Request_i = 4'b0000;
      checks++;
      if (seen !== 4'b0001 || BCD_o !== 12'h040) begin
         errors++;
         $display("FAIL rr_third got done=%b bcd=%h exp 0001/040", seen, BCD_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_shift();
      logic [3:0] seen;
      logic [3:0] stray;
      int         n;
      Binary_i  = {8'd99, 8'd0, 8'd0, 8'd100};
      Request_i = 4'b0001;
      tick();
      Request_i = 4'b0000;
      tick();
      tick();
      tick();
      Reset = 1'b1;
      #1;
      checks++;
      if ({Grant_o, Done_o, BCD_o, Busy_o} !== 21'd0) begin
         errors++;
         $display("FAIL midreset_async got grant=%b done=%b bcd=%h busy=%b exp all zero",
                  Grant_o, Done_o, BCD_o, Busy_o);
      end
      tick();
      Reset = 1'b0;
      stray = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         stray = stray | Done_o | Grant_o;
      end
      checks++;
      if (stray !== 4'b0000 || BCD_o !== 12'h000) begin
         errors++;
         $display("FAIL midreset_quiet got activity=%b bcd=%h exp 0000/000", stray, BCD_o);
      end
      Request_i = 4'b1000;
      wait_done(40, n, seen);
      Request_i = 4'b0000;
      checks++;
      if (seen !== 4'b1000 || BCD_o !== 12'h099 || n !== 9) begin
         errors++;
         $display("FAIL midreset_after got done=%b bcd=%h edges=%0d exp 1000/099/9",
                  seen, BCD_o, n);
      end
      tick();
   endtask

   task automatic test_input_change();
      logic [3:0] seen;
      int         n;
      Binary_i  = 32'd10;
      Request_i = 4'b0001;
      tick();
      checks++;
      if (Grant_o !== 4'b0001) begin
         errors++;
         $display("FAIL change_grant got=%b exp=0001", Grant_o);
      end
      tick();
      Binary_i  = {8'd77, 8'd66, 8'd55, 8'd200};
      Request_i = 4'b1110;
      wait_done(40, n, seen);
      Request_i = 4'b0000;
      checks++;
      if (seen !== 4'b0001 || BCD_o !== 12'h010) begin
         errors++;
         $display("FAIL change_result got done=%b bcd=%h exp 0001/010", seen, BCD_o);
      end
      tick();
   endtask

   task automatic test_sweep();
      logic [3:0] seen;
      int         n;
      int         bad;
      bad       = 0;
      Request_i = 4'b1000;
      for (int v = 0; v < 256; v++) begin
         Binary_i[31:24] = 8'(v);
         wait_done(40, n, seen);
         checks++;
         if (seen !== 4'b1000 || BCD_o !== to_bcd(v)) begin
            errors++;
            bad++;
            if (bad <= 8) begin
               $display("FAIL sweep v=%0d got done=%b bcd=%h exp 1000/%h",
                        v, seen, BCD_o, to_bcd(v));
            end
         end
      end
      Request_i = 4'b0000;
      tick();
   endtask

   initial begin
      Reset     = 1'b1;
      Request_i = '0;
      Binary_i  = '0;
      test_reset();
      test_single();
      test_all_four();
      test_round_robin();
      test_reset_mid_shift();
      test_input_change();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_conversion_arbiter.md
BCD_CONVERSION_ARBITER -- requirements
Module: bcd_conversion_arbiter

Interface
REQ-001 The block SHALL have parameter INPUT_BITS, default 8, meaning the width of each requester's binary operand.
REQ-002 The block SHALL have parameter OUTPUT_DIGITS, default 3, meaning the number of BCD digits produced.
REQ-003 The block SHALL have parameter REQUESTERS, default 4, meaning the number of requesters sharing one converter.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Request_i, input, REQUESTERS bits: level request per requester.
REQ-007 The block SHALL have port Binary_i, input, REQUESTERS*INPUT_BITS bits: operand of requester n at [n*INPUT_BITS +: INPUT_BITS].
REQ-008 The block SHALL have port Grant_o, output, REQUESTERS bits: one-hot, marks the requester being converted.
REQ-009 The block SHALL have port Done_o, output, REQUESTERS bits: one-hot, one-cycle completion pulse.
REQ-010 The block SHALL have port BCD_o, output, OUTPUT_DIGITS*4 bits: last result, digit d at [d*4 +: 4].
REQ-011 The block SHALL have port Busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The controller SHALL implement states IDLE, SHIFT and DONE.
REQ-013 In IDLE with Request_i nonzero at a rising edge, the block SHALL pick the winner by round-robin, latch its operand into the binary shift register, clear the BCD scratch register, set Grant_o for the winner, zero the iteration counter and enter SHIFT.
REQ-014 Round-robin SHALL search from the pointer upward, wrapping modulo REQUESTERS; after each DONE the pointer SHALL become winner+1 (mod REQUESTERS).
REQ-015 In SHIFT, each edge SHALL perform one double-dabble iteration: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one.
REQ-016 SHIFT SHALL last exactly INPUT_BITS cycles, then enter DONE.
REQ-017 On the edge entering DONE, BCD_o SHALL load the final scratch value.
REQ-018 While in DONE, Done_o SHALL be high for the winner only, for exactly one cycle.
REQ-019 In DONE, Grant_o SHALL be low.
REQ-020 DONE SHALL always return to IDLE; a still-high request SHALL be arbitrated as a new request.
REQ-021 Latency from the sampling edge to Done_o high SHALL be INPUT_BITS+1 cycles, with throughput of one conversion per INPUT_BITS+2 cycles.
REQ-022 Binary_i SHALL be sampled only at the grant edge; later changes, and Request_i changes during SHIFT, SHALL NOT affect the conversion in progress.
REQ-023 BCD_o SHALL hold its value until the next DONE.
REQ-024 If the value exceeds OUTPUT_DIGITS digits, only the low OUTPUT_DIGITS digits SHALL be output, with no error flag.

Reset
REQ-025 Reset SHALL asynchronously force: state IDLE, Grant_o=0, Done_o=0, Busy_o=0, BCD_o=0, pointer=0, counter=0, scratch=0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the conversion with no Done_o pulse.
REQ-027 After reset deasserts, the first edge with a request SHALL be arbitrated normally.

Structure
REQ-028 A shared package bcd_pkg SHALL hold the state encoding and a clog2 helper for the counter width.
REQ-029 One combinational sub-module, double_dabble_step, SHALL implement a single add-3-and-shift iteration over OUTPUT_DIGITS digits.

Verification
REQ-030 Scenario: requester 0 alone, Binary=255 -> Grant_o=0001 for 8 cycles, then Done_o=0001 for one cycle, 9 cycles after the sampling edge, with BCD_o=0x255.
REQ-031 Scenario: all four request simultaneously with 12, 34, 56, 78 after reset -> served in order 0,1,2,3 with BCD_o 0x012, 0x034, 0x056, 0x078, 10 cycles apart.
REQ-032 Scenario: after requester 1 is served, requesters 0 and 2 request together -> requester 2 is served first, then requester 0.
REQ-033 Scenario: Reset pulse in the 4th SHIFT cycle -> all outputs 0 and no Done_o; a following request from requester 3 with 99 -> BCD_o=0x099.
REQ-034 Scenario: requester 3 is driven with every value 0..255 -> BCD_o decodes to the same value every time, including 0 -> 0x000.
REQ-035 Scenario: Binary_i changed from 10 to 200 one cycle after grant -> result 0x010.
